pudding_chain_driver: RTL and testbench

- Host-side controller for the PUDDING configuration chain: a CHAIN_LEN-bit daisychain shift register plus a parallel state register.
- Generates the chain pin sequence (datum, shift, transfer, dir) for two operations:
  - Write: serialise a parallel word into the daisychain, then commit it to state.
  - Read: copy state into the daisychain, shift it out through the chain MSB tap, and capture it in parallel.
- Sits between an on-chip/test master and the chain's ui_in[3:0]/uo_out[7] pins; runs on the same clock as the chain.

---
 rtl/pudding_chain_driver.sv | 147 ++++++++++++++
 tb/tb_pudding_chain_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pudding_chain_driver.sv
// Host-side sequencer for the PUDDING configuration chain: serialises writes into
// the daisychain and commits them, or fetches state and reads it back out.
module pudding_chain_driver #(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned SLOT      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_write,
  input  logic                 start_read,
  input  logic [CHAIN_LEN-1:0] wdata,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 chain_datum,
  output logic                 chain_shift,
  output logic                 chain_transfer,
  output logic                 chain_dir,
  input  logic                 chain_q
);

  localparam int unsigned BIT_W  = $clog2(CHAIN_LEN) + 1;
  localparam int unsigned SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT - 1);

  typedef enum logic [2:0] {
    IDLE, W_SHIFT, W_COMMIT, R_FETCH, R_SETTLE, R_SHIFT, DONE
  } state_t;

  state_t               state, state_d;
  logic [BIT_W-1:0]     bit_cnt, bit_d;
  logic [SLOT_W-1:0]    slot_cnt, slot_d;
  logic [CHAIN_LEN-1:0] sreg, sreg_d;
  logic [CHAIN_LEN-1:0] rdata_shift, rshift_d;
  logic [CHAIN_LEN-1:0] rdata_d;
  logic                 busy_d, done_d;
  logic                 datum_d, shift_d, transfer_d, dir_d;

  // State, counters and all outputs share one register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      slot_cnt       <= '0;
      sreg           <= '0;
      rdata_shift    <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      chain_datum    <= 1'b0;
      chain_shift    <= 1'b0;
      chain_transfer <= 1'b0;
      chain_dir      <= 1'b0;
    end else begin
      state          <= state_d;
      bit_cnt        <= bit_d;
      slot_cnt       <= slot_d;
      sreg           <= sreg_d;
      rdata_shift    <= rshift_d;
      rdata          <= rdata_d;
      busy           <= busy_d;
      done           <= done_d;
      chain_datum    <= datum_d;
      chain_shift    <= shift_d;
      chain_transfer <= transfer_d;
      chain_dir      <= dir_d;
    end
  end

  // Next state; outputs are decoded from the next state so pins line up with it.
  always_comb begin
    state_d    = state;
    bit_d      = bit_cnt;
    slot_d     = slot_cnt;
    sreg_d     = sreg;
    rshift_d   = rdata_shift;
    rdata_d    = rdata;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    datum_d    = 1'b0;
    shift_d    = 1'b0;
    transfer_d = 1'b0;
    dir_d      = chain_dir;

    case (state)
      IDLE: begin
        if (start_write) begin
          state_d = W_SHIFT;
          sreg_d  = wdata;
          bit_d   = '0;
          slot_d  = '0;
        end else if (start_read) begin
          state_d = R_FETCH;
        end
      end
      W_SHIFT, R_SHIFT: begin
        // Slot cycle 0 is at least one cycle after the previous shift edge.
        if (state == R_SHIFT && slot_cnt == '0)
          rshift_d = {rdata_shift[CHAIN_LEN-2:0], chain_q};
        if (slot_cnt == LAST_SLOT) begin
          slot_d = '0;
          if (state == W_SHIFT)
            sreg_d = {sreg[CHAIN_LEN-2:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            bit_d = '0;
            if (state == W_SHIFT) begin
              state_d = W_COMMIT;
            end else begin
              state_d = DONE;
              rdata_d = rdata_shift;
            end
          end else begin
            bit_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          slot_d = slot_cnt + SLOT_W'(1);
        end
      end
      W_COMMIT: state_d = DONE;
      R_FETCH:  state_d = R_SETTLE;
      R_SETTLE: begin
        state_d = R_SHIFT;
        bit_d   = '0;
        slot_d  = '0;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    shift_d    = (state_d == W_SHIFT || state_d == R_SHIFT) && (slot_d == LAST_SLOT);
    transfer_d = (state_d == W_COMMIT) || (state_d == R_FETCH);
    if (state_d == W_COMMIT)
      dir_d = 1'b1;
    else if (state_d == R_FETCH)
      dir_d = 1'b0;

    // Reads recirculate chain_q so the daisychain ends up restored.
    if (state_d == W_SHIFT)
      datum_d = sreg_d[CHAIN_LEN-1];
    else if (state_d == R_SHIFT)
      datum_d = (state == R_SHIFT && slot_cnt == '0) ? chain_q : chain_datum;
  end

endmodule

// File: tb/tb_pudding_chain_driver.sv
// Directed bench: two driver instances, each paired with a behavioural chain model.
module tb_pudding_chain_driver;

  localparam int unsigned N0 = 128;
  localparam int unsigned S0 = 2;
  localparam int unsigned N1 = 16;
  localparam int unsigned S1 = 4;

  localparam logic [127:0] W1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W2  = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [127:0] ONE = {128{1'b1}};
  localparam logic [127:0] ALT = {64{2'b10}};

  logic clk = 1'b0;
  logic rst_n, chain_rst_n;
  int   cyc = 0;

  logic          sw0, sr0, busy0, done0, d0, sh0, tr0, dr0, q0;
  logic [N0-1:0] wd0, rd0;
  logic          sw1, sr1, busy1, done1, d1, sh1, tr1, dr1, q1;
  logic [N1-1:0] wd1, rd1;

  logic [N0-1:0] daisy0, cstate0;
  logic [N1-1:0] daisy1, cstate1;

  int nshift0 = 0, nxfer0 = 0, ndone0 = 0, gap0 = 0, last0 = -1;
  int nshift1 = 0, nxfer1 = 0, ndone1 = 0, gap1 = 0, last1 = -1;
  logic xdir0 = 1'b0, xdir1 = 1'b0;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pudding_chain_driver #(.CHAIN_LEN(N0), .SLOT(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_write(sw0), .start_read(sr0), .wdata(wd0),
    .rdata(rd0), .busy(busy0), .done(done0), .chain_datum(d0), .chain_shift(sh0),
    .chain_transfer(tr0), .chain_dir(dr0), .chain_q(q0));

  pudding_chain_driver #(.CHAIN_LEN(N1), .SLOT(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_write(sw1), .start_read(sr1), .wdata(wd1),
    .rdata(rd1), .busy(busy1), .done(done1), .chain_datum(d1), .chain_shift(sh1),
    .chain_transfer(tr1), .chain_dir(dr1), .chain_q(q1));

  // Chain models keep their own reset so committed state survives a driver reset.
  assign q0 = daisy0[N0-1];
  assign q1 = daisy1[N1-1];

  always @(posedge clk) begin
    if (!chain_rst_n) begin
      daisy0 <= '0; cstate0 <= '0;
    end else begin
      if (sh0) daisy0 <= {daisy0[N0-2:0], d0};
      else if (tr0 && !dr0) daisy0 <= cstate0;
      if (tr0 && dr0) cstate0 <= daisy0;
    end
  end

  always @(posedge clk) begin
    if (!chain_rst_n) begin
      daisy1 <= '0; cstate1 <= '0;
    end else begin
      if (sh1) daisy1 <= {daisy1[N1-2:0], d1};
      else if (tr1 && !dr1) daisy1 <= cstate1;
      if (tr1 && dr1) cstate1 <= daisy1;
    end
  end

  // Pin monitors: pulse counts and shift spacing within an operation.
  always @(posedge clk) begin
    if (!rst_n) begin
      last0 = -1;
    end else begin
      if (done0) begin ndone0++; last0 = -1; end
      if (sh0) begin
        if (last0 >= 0 && cyc - last0 != int'(S0)) gap0++;
        last0 = cyc;
        nshift0++;
      end
      if (tr0) begin nxfer0++; xdir0 = dr0; end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      last1 = -1;
    end else begin
      if (done1) begin ndone1++; last1 = -1; end
      if (sh1) begin
        if (last1 >= 0 && cyc - last1 != int'(S1)) gap1++;
        last1 = cyc;
        nshift1++;
      end
      if (tr1) begin nxfer1++; xdir1 = dr1; end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request on instance d and return accept-to-done latency (inclusive).
  task automatic run_op(input int d, input bit wr, input bit rd, input logic [127:0] v,
                        input int poke, output int lat);
    int c0;
    bit seen;
    @(negedge clk);
    if (d == 0) begin sw0 = wr; sr0 = rd; wd0 = v; end
    else        begin sw1 = wr; sr1 = rd; wd1 = v[N1-1:0]; end
    @(posedge clk);
    #1 c0 = cyc;
    lat  = -1;
    seen = 1'b0;
    for (int it = 0; it < 2000 && !seen; it++) begin
      @(negedge clk);
      if (d == 0) begin sw0 = 1'b0; sr0 = (it == poke); end
      else        begin sw1 = 1'b0; sr1 = (it == poke); end
      if ((d == 0) ? done0 : done1) begin
        seen = 1'b1;
        lat  = cyc - c0 + 1;
        chk("busy_at_done", 128'((d == 0) ? busy0 : busy1), 128'(1));
      end
    end
    if (!seen) chk("done_timeout", 128'(0), 128'(1));
    @(negedge clk);
    chk("done_one_cycle", 128'((d == 0) ? {done0, busy0} : {done1, busy1}), 128'(0));
  endtask

  initial begin
    int lat, s0, x0, s1, dn0;
    logic [5:0] idle_or;
    rst_n = 1'b0; chain_rst_n = 1'b0;
    sw0 = 1'b0; sr0 = 1'b0; wd0 = '0;
    sw1 = 1'b0; sr1 = 1'b0; wd1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; chain_rst_n = 1'b1;

    // Idle after reset
    idle_or = '0;
    repeat (10) begin
      @(negedge clk);
      idle_or |= {busy0, done0, d0, sh0, tr0, dr0};
    end
    chk("idle_pins", 128'(idle_or), 128'(0));
    chk("idle_rdata", rd0, 128'(0));
    chk("idle_pulses", 128'(nshift0 + nxfer0), 128'(0));
    chk("idle_chain", {daisy0[63:0], cstate0[63:0]}, 128'(0));

    // Write W1
    s0 = nshift0; x0 = nxfer0;
    run_op(0, 1'b1, 1'b0, W1, -1, lat);
    chk("w1_latency", 128'(lat), 128'(N0 * S0 + 2));
    chk("w1_shifts", 128'(nshift0 - s0), 128'(N0));
    chk("w1_xfers", 128'(nxfer0 - x0), 128'(1));
    chk("w1_dir", 128'(xdir0), 128'(1));
    chk("w1_state", cstate0, W1);
    chk("w1_daisy", daisy0, W1);
    chk("w1_gaps", 128'(gap0), 128'(0));

    // Write W2 then read it back
    run_op(0, 1'b1, 1'b0, W2, -1, lat);
    chk("w2_state", cstate0, W2);
    s0 = nshift0; x0 = nxfer0;
    run_op(0, 1'b0, 1'b1, '0, -1, lat);
    chk("r2_latency", 128'(lat), 128'(N0 * S0 + 3));
    chk("r2_shifts", 128'(nshift0 - s0), 128'(N0));
    chk("r2_xfers", 128'(nxfer0 - x0), 128'(1));
    chk("r2_dir", 128'(xdir0), 128'(0));
    chk("r2_rdata", rd0, W2);
    chk("r2_daisy_restored", daisy0, W2);
    chk("r2_gaps", 128'(gap0), 128'(0));

    // Simultaneous starts plus a mid-write read pulse: only the write runs
    s0 = nshift0; x0 = nxfer0;
    run_op(0, 1'b1, 1'b1, ONE, 50, lat);
    chk("both_latency", 128'(lat), 128'(N0 * S0 + 2));
    repeat (20) @(negedge clk);
    chk("both_idle", 128'({busy0, done0}), 128'(0));
    chk("both_xfers", 128'(nxfer0 - x0), 128'(1));
    chk("both_shifts", 128'(nshift0 - s0), 128'(N0));
    chk("both_state", cstate0, ONE);
    chk("both_rdata_held", rd0, W2);

    // Reset in the middle of a write
    s0 = nshift0; dn0 = ndone0;
    @(negedge clk);
    sw0 = 1'b1; wd0 = ALT;
    @(negedge clk);
    sw0 = 1'b0;
    for (int it = 0; it < 1000 && (nshift0 - s0) < 40; it++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pins", 128'({busy0, done0, d0, sh0, tr0, dr0}), 128'(0));
    chk("rst_rdata", rd0, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_no_done", 128'(ndone0 - dn0), 128'(0));
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_shifts", 128'(nshift0 - s0), 128'(40));
    chk("rst_state_kept", cstate0, ONE);

    // Small instance: CHAIN_LEN=16, SLOT=4
    s1 = nshift1;
    run_op(1, 1'b1, 1'b0, 128'hA5C3, -1, lat);
    chk("s4_w_latency", 128'(lat), 128'(66));
    chk("s4_state", 128'(cstate1), 128'hA5C3);
    run_op(1, 1'b0, 1'b1, '0, -1, lat);
    chk("s4_r_latency", 128'(lat), 128'(67));
    chk("s4_rdata", 128'(rd1), 128'hA5C3);
    chk("s4_daisy", 128'(daisy1), 128'hA5C3);
    chk("s4_shifts", 128'(nshift1 - s1), 128'(32));
    chk("s4_gaps", 128'(gap1), 128'(0));
    chk("s4_dir", 128'(xdir1), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
